// File: rtl/periodic_sampler_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periodic_sampler_gen_pkg
// Purpose  : Shared state encodings and period clamp for the periodic sampler
//            family.
// Revision : 1.0 - initial release
// ============================================================================
package periodic_sampler_gen_pkg;

    // Sampler control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    // Shortest period the counter can realise (one COUNT cycle + SAMPLE)
    localparam int C_PERIOD_MIN = 2;

    // Effective period: 0 selects the default, 1 is clamped up to the minimum
    function automatic logic [31:0] eff_period(input logic [31:0] per,
                                               input logic [31:0] nper);
        if (per == 32'd0) begin
            return nper;
        end else if (per == 32'd1) begin
            return 32'(C_PERIOD_MIN);
        end
        return per;
    endfunction

endpackage
`default_nettype wire

// File: rtl/periodic_sampler_gen_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : sampler_tick_counter
// Purpose  : Loadable down-counter for the sampler period. Flags when the
//            count reaches two and never decrements below that value.
// Revision : 1.0 - initial release
// ============================================================================
module sampler_tick_counter #(
    parameter int             CW      = 8,
    parameter logic [CW-1:0]  RST_VAL = '0
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] load_val_i,
    output logic          at_two_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_two_o = (count_q == CW'(2));

    // Next count: load has priority, decrement stops at two
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && !at_two_o) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, reset to the default period
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/periodic_sampler_gen.sv
`default_nettype none
// ============================================================================
// Module   : periodic_sampler_gen
// Purpose  : Periodic / one-shot sampler. Every P clocks captures the data
//            field and a selected address field of d, then pulses stb.
// Revision : 1.0 - initial release
// ============================================================================
module periodic_sampler_gen
    import periodic_sampler_gen_pkg::*;
#(
    parameter int ZW   = 8,
    parameter int AW   = 4,
    parameter int NCH  = 2,
    parameter int SW   = 1,
    parameter int CW   = 8,
    parameter int NPER = 10
) (
    input  logic                  clock,
    input  logic                  reset_,
    input  logic [ZW+NCH*AW-1:0]  d,
    input  logic [SW-1:0]         sel,
    input  logic                  mode,
    input  logic                  start,
    input  logic [CW-1:0]         per,
    output logic [ZW-1:0]         z,
    output logic [AW-1:0]         a,
    output logic                  stb,
    output logic                  sel_err
);

    state_e          state_q, state_d;
    logic [ZW-1:0]   z_q, z_d;
    logic [AW-1:0]   a_q, a_d;
    logic            stb_q, stb_d;
    logic            err_q, err_d;

    logic [AW-1:0]   fields [NCH];
    logic [AW-1:0]   field_sel;
    logic            sel_ok;
    logic [CW-1:0]   period_eff;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_at_two;

    // Address fields, field 0 is the most significant one above the data
    for (genvar k = 0; k < NCH; k++) begin : g_field
        assign fields[k] = d[ZW+AW*(NCH-k)-1 -: AW];
    end

    // Field select; out-of-range indices leave sel_ok low
    always_comb begin
        field_sel = '0;
        sel_ok    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SW'(k)) begin
                field_sel = fields[k];
                sel_ok    = 1'b1;
            end
        end
    end

    assign period_eff = CW'(eff_period(32'(per), 32'(NPER)));

    sampler_tick_counter #(
        .CW      (CW),
        .RST_VAL (CW'(NPER))
    ) u_tick (
        .clock_i    (clock),
        .reset_n_i  (reset_),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (period_eff),
        .at_two_o   (cnt_at_two)
    );

    // Next-state and output decode; stb/sel_err default low every cycle
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        z_d      = z_q;
        a_d      = a_q;
        stb_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!mode || start) begin
                    cnt_load = 1'b1;
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                cnt_dec = 1'b1;
                if (cnt_at_two) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                z_d   = d[ZW-1:0];
                stb_d = 1'b1;
                if (sel_ok) begin
                    a_d = field_sel;
                end else begin
                    err_d = 1'b1;
                end
                if (!mode) begin
                    cnt_load = 1'b1;
                    state_d  = ST_COUNT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            a_q     <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            a_q     <= a_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign z       = z_q;
    assign a       = a_q;
    assign stb     = stb_q;
    assign sel_err = err_q;

endmodule
`default_nettype wire
